// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter
//   Round-robin arbiter that merges N_REQ valid/ready request streams into a
//   single registered output stream (one output register, 1-cycle latency,
//   full 1 beat/cycle throughput).
//
//   Optional feature: define ARB_BURST_EN to let a granted requester keep
//   priority for up to BURST_LEN consecutive beats before rotation.
//
// Ports
//   clk        : clock, all state updates on rising edge
//   rst        : asynchronous active-high reset
//   req_valid  : [N_REQ] per-requester valid
//   req_data   : [N_REQ*DATA_WIDTH] per-requester payload, channel i at
//                bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  : [N_REQ] one-hot (or zero) grant/ready back to requesters
//   out_valid  : registered merged valid
//   out_data   : registered merged payload
//   out_src    : registered index of the requester that supplied out_data
//   out_ready  : downstream ready
//   idle       : no beat held and no request pending
module handshake_rr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [N_REQ-1:0]                            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]                 req_data,
  output logic [N_REQ-1:0]                            req_ready,
  output logic                                        out_valid,
  output logic [DATA_WIDTH-1:0]                       out_data,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] out_src,
  input  logic                                        out_ready,
  output logic                                        idle
);

  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 16 || BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_param
    $error("handshake_rr_arbiter: parameter out of legal range");
  end

  function automatic logic [SRC_W-1:0] ptr_inc(input logic [SRC_W-1:0] p);
    if (p == SRC_W'(N_REQ - 1)) return '0;
    return p + 1'b1;
  endfunction

  logic [SRC_W-1:0]      prio_ptr;
  logic [SRC_W-1:0]      grant_idx;
  logic                  grant_found;
  logic                  accept;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] sel_data;

  // Stage 0: arbitration (depends only on valids, pointer and output state)
  assign accept = !out_valid || out_ready;
  assign xfer   = accept && grant_found;
  assign idle   = !out_valid && (req_valid == '0);

  always_comb begin
    int j;
    j           = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(prio_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!grant_found && req_valid[j]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(j);
      end
    end
  end

  // req_ready is additionally masked by rst so nothing is acknowledged while
  // the output register is being cleared.
  always_comb begin
    req_ready = '0;
    if (!rst && xfer) req_ready[grant_idx] = 1'b1;
  end

  assign sel_data = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  // Stage 1: output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARB_BURST_EN
  logic [7:0] burst_cnt;
  logic [8:0] run_len;

  // Length of the current run including this beat; a grant to a requester
  // other than the pointer holder starts a fresh run.
  assign run_len = {1'b0, (grant_idx == prio_ptr) ? burst_cnt : 8'd0} + 9'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_ptr  <= '0;
      burst_cnt <= '0;
    end else if (xfer) begin
      if (run_len >= 9'(BURST_LEN)) begin
        prio_ptr  <= ptr_inc(grant_idx);
        burst_cnt <= '0;
      end else begin
        prio_ptr  <= grant_idx;
        burst_cnt <= run_len[7:0];
      end
    end else if (accept && !req_valid[prio_ptr]) begin
      // Holder went away while the output could accept: rotate on.
      prio_ptr  <= ptr_inc(prio_ptr);
      burst_cnt <= '0;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_ptr <= '0;
    end else if (xfer) begin
      prio_ptr <= ptr_inc(grant_idx);
    end
  end
`endif

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
module tb_handshake_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_ready;
  logic            idle;

  handshake_rr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state: the output register contents plus the rotation
  // pointer and the current run length of the pointer holder
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_ptr;
  int            m_cnt;
  bit            last_xfer;
  bit            track;
  int            delivered;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: check handshake outputs against the model before the
  // edge, advance the model with the spec's rules, check registers after.
  task automatic step();
    bit            accept, found;
    int            g, idx, run;
    logic [N-1:0]  er;
    logic [DW-1:0] gd;
    #1;
    accept = !m_valid || out_ready;
    found = 0; g = 0;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (!found && req_valid[idx]) begin found = 1; g = idx; end
    end
    er = '0;
    if (accept && found) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("idle", idle, (!m_valid && req_valid == '0));
    if (track && out_valid && out_ready) begin
      chk("beat_data", out_data, delivered);
      chk("beat_src", out_src, 1);
      delivered++;
    end
    gd = req_data[g*DW +: DW];
    @(posedge clk); #1;
    last_xfer = accept && found;
    if (last_xfer) begin
      m_valid = 1'b1; m_data = gd; m_src = g;
`ifdef ARB_BURST_EN
      run = (g == m_ptr) ? m_cnt + 1 : 1;
      if (run >= BL) begin m_ptr = (g + 1) % N; m_cnt = 0; end
      else begin m_ptr = g; m_cnt = run; end
`else
      run = 0;
      m_ptr = (g + 1) % N;
`endif
    end else begin
      if (out_ready) m_valid = 1'b0;
`ifdef ARB_BURST_EN
      if (accept) begin m_ptr = (m_ptr + 1) % N; m_cnt = 0; end
`endif
    end
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_src", out_src, m_src);
  endtask

`ifdef ARB_BURST_EN
  int e31[6] = '{0, 0, 0, 0, 1, 1};
  int e32[3] = '{1, 1, 1};
  int e34[3] = '{2, 2, 3};
`else
  int e31[6] = '{0, 1, 2, 3, 0, 1};
  int e32[3] = '{3, 1, 3};
  int e34[3] = '{2, 3, 3};
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, guard;
    track = 0; delivered = 0;
    rst = 1'b0; req_valid = '1; out_ready = 1'b1;
    randomize_data();
    model_reset();

    // reset state, req_ready gated even with every request valid
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_req_ready", req_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    req_valid = '0;

    // all valid, downstream always ready: rotation at one beat per cycle
    req_valid = '1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      randomize_data();
      step();
      chk("seq_all_valid", out_src, e31[i]);
    end

    // stall with requesters 1 and 3 pending
    do_reset();
    req_valid = 4'b1010; out_ready = 1'b0;
    step();
    chk("stall_first", out_src, 1);
    for (int i = 0; i < 5; i++) begin
      randomize_data();
      step();
      chk("stall_hold_valid", out_valid, 1);
      chk("stall_hold_src", out_src, 1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("after_stall", out_src, e32[i]);
    end

    // requester 2 drops out, requester 3 stays
    do_reset();
    req_valid = 4'b1100; out_ready = 1'b1;
    step(); chk("drop_seq0", out_src, e34[0]);
    step(); chk("drop_seq1", out_src, e34[1]);
    req_valid = 4'b1000;
    step(); chk("drop_seq2", out_src, e34[2]);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      out_ready = 1'($urandom_range(0, 1));
      randomize_data();
      step();
    end

    // asynchronous reset mid-stream with a beat held
    req_valid = '1; out_ready = 1'b0;
    step();
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", req_ready, 0);
    #1 rst = 1'b0;
    model_reset();
    req_valid = 4'b0110; out_ready = 1'b1;
    step();
    chk("post_rst_grant", out_src, 1);

    // single requester, random backpressure, ordered delivery then drain
    do_reset();
    track = 1; delivered = 0; sent = 0; guard = 0;
    randomize_data();
    req_data[1*DW +: DW] = '0;
    req_valid = 4'b0010;
    while (sent < 100 && guard < 1000) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      guard++;
      if (last_xfer) begin
        sent++;
        req_data[1*DW +: DW] = DW'(sent);
      end
      if (sent == 100) req_valid = '0;
    end
    chk("single_sent", sent, 100);
    req_valid = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) step();
    chk("single_delivered", delivered, 100);
    #1;
    chk("idle_after_drain", idle, 1);
    track = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
